// File: rtl/turn_sequencer.sv
// turn_sequencer: two-player turn controller for the ui_render animators.
// A move request loads the active player's target x, strobes that player's
// animator, waits for its turn_done (or a timeout), commits the position,
// checks for a win at the flag and then passes the turn to the other player.
//
// Handshake semantics: i_move_req is a one-cycle request and is accepted only
// when the sequencer is idle (o_busy low) and the game is not over. Requests
// at any other time, and requests with zero steps, are dropped without effect.
// o_busy stays high from acceptance until the move has been committed.
// o_pN_move_start is a level strobe held for START_HOLD cycles with
// o_pN_target_x already stable. i_pN_turn_done comes from the render clock
// domain and is synchronised here. Only its rising edge counts, and only while
// the sequencer is waiting on that player.
module turn_sequencer #(
  parameter int START_X      = 20,
  parameter int TILE_SPACING = 60,
  parameter int MAX_X        = 620,
  parameter int START_HOLD   = 8,
  parameter int TIMEOUT_CYC  = 2**26
) (
  input  logic       clk_100mhz,
  input  logic       btn_reset,
  input  logic       i_move_req,
  input  logic [1:0] i_move_steps,
  input  logic       i_p1_turn_done,
  input  logic       i_p2_turn_done,
  output logic [9:0] o_p1_target_x,
  output logic       o_p1_move_start,
  output logic [9:0] o_p2_target_x,
  output logic       o_p2_move_start,
  output logic       o_active_player,
  output logic       o_busy,
  output logic       o_game_over,
  output logic [1:0] o_winner,
  output logic       o_timeout_err,
  output logic [3:0] o_p1_tile,
  output logic [3:0] o_p2_tile,
  output logic [2:0] o_dbg_state
);

  localparam int CNT_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int HOLD_W = $clog2(START_HOLD + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_DONE    = HOLD_W'(START_HOLD);
  localparam logic [9:0]        START_X10    = 10'(START_X);
  localparam logic [9:0]        MAX_X10      = 10'(MAX_X);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [2:0]          r_p1_sync;
  logic [2:0]          r_p2_sync;
  logic [9:0]          r_p1_target;
  logic [9:0]          r_p2_target;
  logic [9:0]          r_p1_cur;
  logic [9:0]          r_p2_cur;
  logic [3:0]          r_p1_tile;
  logic [3:0]          r_p2_tile;
  logic                r_p1_start;
  logic                r_p2_start;
  logic                r_active;
  logic                r_busy;
  logic                r_game_over;
  logic [1:0]          r_winner;
  logic                r_timeout_err;

  logic                w_p1_done_evt;
  logic                w_p2_done_evt;
  logic                w_done_act;
  logic [9:0]          w_act_cur;
  logic [9:0]          w_act_target;
  logic [10:0]         w_sum;
  logic [9:0]          w_new_x;
  logic [3:0]          w_commit_tile;
  logic                w_accept;
  logic                w_strobe;
  logic                w_timeout;
  logic                w_commit;
  logic                w_win;

  // Rising edge of the synchronised done level, one clk_100mhz cycle wide.
  assign w_p1_done_evt = r_p1_sync[1] & ~r_p1_sync[2];
  assign w_p2_done_evt = r_p2_sync[1] & ~r_p2_sync[2];
  assign w_done_act    = r_active ? w_p2_done_evt : w_p1_done_evt;

  // New position is formed in 11 bits so an overshoot past the flag is seen
  // before clamping.
  assign w_act_cur     = r_active ? r_p2_cur : r_p1_cur;
  assign w_act_target  = r_active ? r_p2_target : r_p1_target;
  assign w_sum         = {1'b0, w_act_cur} + (11'(i_move_steps) * 11'(TILE_SPACING));
  assign w_new_x       = (w_sum > 11'(MAX_X)) ? MAX_X10 : w_sum[9:0];
  assign w_commit_tile = 4'((w_act_target - START_X10) / 10'(TILE_SPACING));

  // Two-flop synchroniser plus an edge-detect flop for each render-domain done.
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) begin
      r_p1_sync <= 3'b000;
      r_p2_sync <= 3'b000;
    end else begin
      r_p1_sync <= {r_p1_sync[1:0], i_p1_turn_done};
      r_p2_sync <= {r_p2_sync[1:0], i_p2_turn_done};
    end
  end

  // FSM state register.
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  // FSM next-state and per-cycle control decode.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_strobe     = 1'b0;
    w_timeout    = 1'b0;
    w_commit     = 1'b0;
    w_win        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_move_req && (i_move_steps != 2'd0) && !r_game_over) begin
          w_accept     = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_hold_cnt == HOLD_DONE) w_next_state = S_WAIT;
        else                         w_strobe     = 1'b1;
      end
      S_WAIT: begin
        if (w_done_act) begin
          w_next_state = S_COMMIT;
        end else if (r_wait_cnt == TIMEOUT_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit = 1'b1;
        if (w_act_target == MAX_X10) begin
          w_win        = 1'b1;
          w_next_state = S_OVER;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_OVER:  w_next_state = S_OVER;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Strobe-hold and timeout counters; each is cleared outside its own state.
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) begin
      r_hold_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (r_state != S_ISSUE) r_hold_cnt <= '0;
      else if (w_strobe)      r_hold_cnt <= r_hold_cnt + 1'b1;
      if (r_state != S_WAIT)  r_wait_cnt <= '0;
      else                    r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Player positions, strobes and game status, updated on accept and commit.
  always_ff @(posedge clk_100mhz or posedge btn_reset) begin
    if (btn_reset) begin
      r_p1_target   <= START_X10;
      r_p2_target   <= START_X10;
      r_p1_cur      <= START_X10;
      r_p2_cur      <= START_X10;
      r_p1_tile     <= 4'd0;
      r_p2_tile     <= 4'd0;
      r_p1_start    <= 1'b0;
      r_p2_start    <= 1'b0;
      r_active      <= 1'b0;
      r_busy        <= 1'b0;
      r_game_over   <= 1'b0;
      r_winner      <= 2'b00;
      r_timeout_err <= 1'b0;
    end else begin
      r_p1_start <= w_strobe & ~r_active;
      r_p2_start <= w_strobe & r_active;
      if (w_accept) begin
        r_busy <= 1'b1;
        if (r_active) r_p2_target <= w_new_x;
        else          r_p1_target <= w_new_x;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_commit) begin
        r_busy <= 1'b0;
        if (r_active) begin
          r_p2_cur  <= r_p2_target;
          r_p2_tile <= w_commit_tile;
        end else begin
          r_p1_cur  <= r_p1_target;
          r_p1_tile <= w_commit_tile;
        end
        if (w_win) begin
          r_game_over <= 1'b1;
          r_winner    <= r_active ? 2'b10 : 2'b01;
        end else begin
          r_active <= ~r_active;
        end
      end
    end
  end

  assign o_p1_target_x   = r_p1_target;
  assign o_p2_target_x   = r_p2_target;
  assign o_p1_move_start = r_p1_start;
  assign o_p2_move_start = r_p2_start;
  assign o_active_player = r_active;
  assign o_busy          = r_busy;
  assign o_game_over     = r_game_over;
  assign o_winner        = r_winner;
  assign o_timeout_err   = r_timeout_err;
  assign o_p1_tile       = r_p1_tile;
  assign o_p2_tile       = r_p2_tile;
  assign o_dbg_state     = r_state;

endmodule
